id_scoreboard: RTL and testbench
================================

Name: id_scoreboard

Overview:
- Parametrised register scoreboard placed beside the decode stage.
- Tracks destination registers with in-flight multi-cycle results (loads, mult/div, future coprocessor ops) using one countdown counter per architectural register.
- Raises a stall for decode on read-after-write (RAW) or write-after-write (WAW) hazards that forwarding from execute/memory cannot cover.
- Generalises the fixed two-read-port forwarding check to NRD read ports and variable result latency.

Parameters:
REG_NUM, 32, number of architectural registers; register 0 hardwired zero, never tracked
ADDR_W, 5, register address width; must satisfy 2**ADDR_W >= REG_NUM
NRD, 2, number of decode read ports checked per cycle
MAX_LAT, 7, largest trackable result latency in cycles
LAT_W, 3, counter width; must satisfy 2**LAT_W > MAX_LAT

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
rd_en_i  in  NRD  per-port read enable from decode
rd_addr_i  in  NRD*ADDR_W  flattened read addresses; port k at [k*ADDR_W +: ADDR_W]
issue_i  in  1  decode presents an instruction for issue this cycle
issue_wreg_i  in  1  issuing instruction writes a register
issue_wd_i  in  ADDR_W  destination register of issuing instruction
issue_lat_i  in  LAT_W  cycles until the result is forwardable; 0 = single-cycle, not tracked
flush_i  in  1  pipeline flush (branch/exception); drops all pending entries
stall_o  out  1  hold decode; the instruction must not issue this cycle
busy_o  out  REG_NUM  bit r set when cnt[r] != 0
pend_cnt_o  out  ADDR_W+1  number of registers currently busy
stall_cnt_o  out  32  stall performance counter (see Optional Feature)

Behaviour:
- State: cnt[r] is LAT_W bits wide, r in 1..REG_NUM-1. cnt[0] is constant 0.
- Reset (rst=1 at clk edge): all cnt=0. stall_o is gated to 0 while rst=1. After reset: busy_o=0, pend_cnt_o=0, stall_cnt_o=0.
- RAW hazard on port k: rd_en_i[k] & (addr_k != 0) & (cnt[addr_k] > 1).
  - cnt==1 means the result is on the forwarding path next cycle. It is not a hazard; decode's existing ex/mem forwarding covers it.
- WAW hazard: issue_wreg_i & (issue_wd_i != 0) & (cnt[issue_wd_i] > eff_lat).
  - eff_lat = min(issue_lat_i, MAX_LAT); values above MAX_LAT saturate.
- stall_o = issue_i & ~rst & ~flush_i & (any RAW | WAW). Purely combinational, zero latency.
- Accepted issue = issue_i & ~stall_o & ~flush_i.
- Per-cycle update, in priority order:
  1. flush_i: all cnt <= 0. Any issue in the same cycle is discarded.
  2. Accepted issue with issue_wreg_i, issue_wd_i != 0 and eff_lat != 0: cnt[issue_wd_i] <= eff_lat. This overrides that register's decrement in the same cycle.
  3. Every other cnt != 0 decrements by 1. Counters at 0 stay at 0 (no wrap).
- Issue to register 0, or with eff_lat=0: no state change.
- busy_o and pend_cnt_o are derived combinationally from cnt. They therefore reflect state one cycle after an update.
- Register addresses >= REG_NUM are treated as never busy.
- Mid-operation reset clears all pending entries immediately at the edge. No partial decrement.

Optional Feature:
- Macro: SCB_STALL_CNT_EN.
- Defined: a 32-bit counter increments on every cycle with stall_o=1 and wraps modulo 2^32. It clears on rst only, not on flush. Its value drives stall_cnt_o.
- Undefined: no counter logic; stall_cnt_o is constant 0.

Test Plan:
1. Reset, then issue wd=5 lat=3. Next cycle read r5 on port 0 with issue_i=1 -> stall_o=1 while cnt=3,2. stall_o=0 when cnt=1. busy_o[5] clears 3 cycles after issue.
2. Issue wd=0 lat=5 -> busy_o stays 0, pend_cnt_o=0. A subsequent read of r0 never stalls.
3. r7 pending with cnt=4; issue wd=7 lat=2 -> stall_o=1 (WAW). After two cycles cnt=2 and the issue is accepted; cnt[7] reloads to 2 that cycle.
4. r3 cnt=3 and r9 cnt=2; assert flush_i together with issue wd=4 lat=5 -> next cycle busy_o=0 and pend_cnt_o=0; r4 is not tracked.
5. NRD=3 build: port 2 reads r12 with cnt=2, ports 0 and 1 idle -> stall_o=1. Drop rd_en_i[2] -> stall_o=0.
6. With SCB_STALL_CNT_EN: 4 stalled cycles then rst -> stall_cnt_o reads 4, then 0 after the reset edge. Without the macro, stall_cnt_o=0 throughout.

Source files
------------

// File: rtl/id_scoreboard_if.sv
// Decode-side handshake bundle for the register scoreboard.
// The master modport is decode, and the slave modport is the scoreboard.
interface id_scoreboard_if #(
  parameter int REG_NUM = 32,
  parameter int ADDR_W  = 5,
  parameter int NRD     = 2,
  parameter int LAT_W   = 3
);
  logic [NRD-1:0]        rd_en_i;
  logic [NRD*ADDR_W-1:0] rd_addr_i;
  logic                  issue_i;
  logic                  issue_wreg_i;
  logic [ADDR_W-1:0]     issue_wd_i;
  logic [LAT_W-1:0]      issue_lat_i;
  logic                  flush_i;
  logic                  stall_o;
  logic [REG_NUM-1:0]    busy_o;
  logic [ADDR_W:0]       pend_cnt_o;
  logic [31:0]           stall_cnt_o;

  modport master (
    output rd_en_i, rd_addr_i, issue_i, issue_wreg_i, issue_wd_i, issue_lat_i, flush_i,
    input  stall_o, busy_o, pend_cnt_o, stall_cnt_o
  );

  modport slave (
    input  rd_en_i, rd_addr_i, issue_i, issue_wreg_i, issue_wd_i, issue_lat_i, flush_i,
    output stall_o, busy_o, pend_cnt_o, stall_cnt_o
  );
endinterface

// File: rtl/id_scoreboard.sv
// Register scoreboard that sits beside decode.
// Each architectural register has one countdown of cycles until its in-flight result
// can be forwarded. Decode is stalled on RAW or WAW hazards that forwarding cannot cover.
// Optional macro SCB_STALL_CNT_EN enables a 32-bit stall performance counter.
module id_scoreboard #(
  parameter int REG_NUM = 32,
  parameter int ADDR_W  = 5,
  parameter int NRD     = 2,
  parameter int MAX_LAT = 7,
  parameter int LAT_W   = 3
) (
  input  logic           clk,
  input  logic           rst,
  id_scoreboard_if.slave sb
);

  // The counter table covers the full address space. Register 0 and any address at or
  // above REG_NUM are held at zero, so an out-of-range address never reads as busy.
  localparam int CNT_N = 2 ** ADDR_W;
  localparam logic [LAT_W-1:0] MAX_LAT_L = LAT_W'(MAX_LAT);
  localparam logic [LAT_W-1:0] ONE_L     = LAT_W'(1);

  logic [LAT_W-1:0]   cnt [CNT_N];
  logic [LAT_W-1:0]   eff_lat;
  logic               raw_hit;
  logic               waw_hit;
  logic               stall;
  logic               load;
  logic [REG_NUM-1:0] busy;
  logic [ADDR_W:0]    pend;

  // Saturate the requested latency to the largest value the counters can track.
  always_comb begin
    eff_lat = (sb.issue_lat_i > MAX_LAT_L) ? MAX_LAT_L : sb.issue_lat_i;
  end

  // RAW: a read of a register whose result is still more than one cycle away.
  // WAW: the new write would complete before the older write that is still in flight.
  always_comb begin
    logic [ADDR_W-1:0] rd_a;
    raw_hit = 1'b0;
    rd_a    = '0;
    for (int k = 0; k < NRD; k++) begin
      rd_a = sb.rd_addr_i[k*ADDR_W +: ADDR_W];
      if (sb.rd_en_i[k] && (cnt[rd_a] > ONE_L)) begin
        raw_hit = 1'b1;
      end
    end
    waw_hit = sb.issue_wreg_i && (cnt[sb.issue_wd_i] > eff_lat);
  end

  // Decode stall and tracked-issue qualification.
  always_comb begin
    stall = sb.issue_i & ~rst & ~sb.flush_i & (raw_hit | waw_hit);
    load  = sb.issue_i & ~stall & ~sb.flush_i & sb.issue_wreg_i &
            (sb.issue_wd_i != '0) & (eff_lat != '0);
  end

  assign sb.stall_o = stall;

  // Counter update. Reset or flush clears the table. A new issue reloads its
  // destination register. All other counters count down to zero.
  always_ff @(posedge clk) begin
    for (int r = 0; r < CNT_N; r++) begin
      if (rst || sb.flush_i || (r == 0) || (r >= REG_NUM)) begin
        cnt[r] <= '0;
      end else if (load && (int'(sb.issue_wd_i) == r)) begin
        cnt[r] <= eff_lat;
      end else if (cnt[r] != '0) begin
        cnt[r] <= cnt[r] - ONE_L;
      end
    end
  end

  // Busy map and population count, derived directly from the counter table.
  always_comb begin
    busy = '0;
    pend = '0;
    for (int r = 1; r < REG_NUM; r++) begin
      busy[r] = (cnt[r] != '0);
      pend    = pend + (ADDR_W + 1)'(busy[r]);
    end
  end

  assign sb.busy_o     = busy;
  assign sb.pend_cnt_o = pend;

`ifdef SCB_STALL_CNT_EN
  logic [31:0] stall_cnt;

  // Count stalled cycles. The counter wraps, and only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign sb.stall_cnt_o = stall_cnt;
`else
  assign sb.stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_id_scoreboard.sv
// Testbench for id_scoreboard.
// The reference model records the absolute cycle at which each register's result
// becomes forwardable. The remaining latency is that cycle minus the current cycle.
module tb_id_scoreboard;
  localparam int REG_NUM = 32;
  localparam int ADDR_W  = 5;
  localparam int MAX_LAT = 7;
  localparam int LAT_W   = 3;
`ifdef SCB_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_scoreboard_if #(.REG_NUM(REG_NUM), .ADDR_W(ADDR_W), .NRD(2), .LAT_W(LAT_W)) sb();
  id_scoreboard #(.REG_NUM(REG_NUM), .ADDR_W(ADDR_W), .NRD(2), .MAX_LAT(MAX_LAT), .LAT_W(LAT_W))
    u_dut (.clk(clk), .rst(rst), .sb(sb));

  id_scoreboard_if #(.REG_NUM(REG_NUM), .ADDR_W(ADDR_W), .NRD(3), .LAT_W(LAT_W)) sb3();
  id_scoreboard #(.REG_NUM(REG_NUM), .ADDR_W(ADDR_W), .NRD(3), .MAX_LAT(MAX_LAT), .LAT_W(LAT_W))
    u_dut3 (.clk(clk), .rst(rst), .sb(sb3));

  int          n_assert = 0;
  int          n_fail   = 0;
  int          edge_n   = 0;
  int          ready_at [REG_NUM];
  logic [31:0] m_stall_cnt;

  function automatic int rem(input int a);
    if (a == 0 || a >= REG_NUM) return 0;
    return (ready_at[a] > edge_n) ? ready_at[a] - edge_n : 0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle. Drive the inputs, check the combinational outputs against the
  // model, clock the design, then advance the model.
  task automatic step(input logic [1:0] en, input int a0, input int a1, input logic iss,
                      input logic wreg, input int wd, input int lat, input logic fl,
                      input logic rs);
    int              eff;
    logic            raw, waw, e_stall;
    logic [31:0]     e_busy;
    int              e_pend;
    sb.rd_en_i      = en;
    sb.rd_addr_i    = {5'(a1), 5'(a0)};
    sb.issue_i      = iss;
    sb.issue_wreg_i = wreg;
    sb.issue_wd_i   = 5'(wd);
    sb.issue_lat_i  = 3'(lat);
    sb.flush_i      = fl;
    rst             = rs;
    #1;
    eff     = (lat > MAX_LAT) ? MAX_LAT : lat;
    raw     = (en[0] && rem(a0) > 1) || (en[1] && rem(a1) > 1);
    waw     = wreg && (rem(wd) > eff);
    e_stall = iss && !rs && !fl && (raw || waw);
    e_busy  = '0;
    e_pend  = 0;
    for (int r = 1; r < REG_NUM; r++) begin
      if (rem(r) > 0) begin
        e_busy[r] = 1'b1;
        e_pend++;
      end
    end
    chk("stall", 64'(sb.stall_o), 64'(e_stall));
    chk("busy", 64'(sb.busy_o), 64'(e_busy));
    chk("pend_cnt", 64'(sb.pend_cnt_o), 64'(e_pend));
    chk("stall_cnt", 64'(sb.stall_cnt_o), CNT_EN ? 64'(m_stall_cnt) : 64'd0);
    @(posedge clk);
    edge_n++;
    if (rs) begin
      for (int r = 0; r < REG_NUM; r++) ready_at[r] = edge_n;
      m_stall_cnt = '0;
    end else begin
      if (e_stall) m_stall_cnt = m_stall_cnt + 32'd1;
      if (fl) begin
        for (int r = 0; r < REG_NUM; r++) ready_at[r] = edge_n;
      end else if (iss && !e_stall && wreg && wd != 0 && eff != 0) begin
        ready_at[wd] = edge_n + eff;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(2'b00, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    m_stall_cnt = '0;
    for (int r = 0; r < REG_NUM; r++) ready_at[r] = 0;
    rst              = 1'b1;
    sb.rd_en_i       = '0;
    sb.rd_addr_i     = '0;
    sb.issue_i       = 1'b0;
    sb.issue_wreg_i  = 1'b0;
    sb.issue_wd_i    = '0;
    sb.issue_lat_i   = '0;
    sb.flush_i       = 1'b0;
    sb3.rd_en_i      = '0;
    sb3.rd_addr_i    = '0;
    sb3.issue_i      = 1'b0;
    sb3.issue_wreg_i = 1'b0;
    sb3.issue_wd_i   = '0;
    sb3.issue_lat_i  = '0;
    sb3.flush_i      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state. An issue during reset is never stalled.
    step(2'b11, 5, 6, 1'b1, 1'b1, 5, 3, 1'b0, 1'b1);

    // Item 1: r5 with latency 3. The read stalls at cnt 3 and 2 and is released at cnt 1.
    step(2'b00, 0, 0, 1'b1, 1'b1, 5, 3, 1'b0, 1'b0);
    chk("r5_busy_after_issue", 64'(sb.busy_o[5]), 64'd1);
    repeat (3) step(2'b01, 5, 0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("r5_clear", 64'(sb.busy_o[5]), 64'd0);

    // Item 2: an issue to r0 is never tracked, and a read of r0 never stalls.
    step(2'b00, 0, 0, 1'b1, 1'b1, 0, 5, 1'b0, 1'b0);
    step(2'b11, 0, 0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("r0_pend", 64'(sb.pend_cnt_o), 64'd0);

    // Item 3: WAW on r7 while cnt=4. The issue is accepted once cnt reaches 2, then reloads to 2.
    step(2'b00, 0, 0, 1'b1, 1'b1, 7, 4, 1'b0, 1'b0);
    repeat (3) step(2'b00, 0, 0, 1'b1, 1'b1, 7, 2, 1'b0, 1'b0);
    step(2'b10, 0, 7, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);

    // Item 4: a flush drops r3 and r9 and discards the same-cycle issue to r4.
    step(2'b00, 0, 0, 1'b1, 1'b1, 9, 3, 1'b0, 1'b0);
    step(2'b00, 0, 0, 1'b1, 1'b1, 3, 3, 1'b0, 1'b0);
    step(2'b11, 3, 9, 1'b1, 1'b1, 4, 5, 1'b1, 1'b0);
    chk("flush_busy", 64'(sb.busy_o), 64'd0);
    chk("flush_pend", 64'(sb.pend_cnt_o), 64'd0);

    // Reset in mid-operation clears pending entries and gates the stall.
    step(2'b00, 0, 0, 1'b1, 1'b1, 11, 7, 1'b0, 1'b0);
    step(2'b01, 11, 0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1);
    chk("midrst_busy", 64'(sb.busy_o), 64'd0);

    // Item 6: four stalled cycles, then a reset.
    step(2'b00, 0, 0, 1'b1, 1'b1, 5, 7, 1'b0, 1'b0);
    repeat (4) step(2'b01, 5, 0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("stall_cnt_4", 64'(sb.stall_cnt_o), CNT_EN ? 64'd4 : 64'd0);
    step(2'b00, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    chk("stall_cnt_rst", 64'(sb.stall_cnt_o), 64'd0);

    // Randomized traffic on a small register window so that hazards occur often.
    for (int i = 0; i < 600; i++) begin
      step(2'($urandom), int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
           ($urandom % 4) != 0, 1'($urandom), int'($urandom_range(0, 9)),
           int'($urandom_range(0, 7)), ($urandom % 30) == 0, ($urandom % 80) == 0);
    end

    // Item 5: three-port instance, with a hazard on port 2 only.
    sb3.issue_i      = 1'b1;
    sb3.issue_wreg_i = 1'b1;
    sb3.issue_wd_i   = 5'd12;
    sb3.issue_lat_i  = 3'd3;
    rst              = 1'b0;
    sb.issue_i       = 1'b0;
    sb.flush_i       = 1'b0;
    @(posedge clk);
    @(negedge clk);
    sb3.issue_i      = 1'b0;
    sb3.issue_wreg_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    sb3.rd_addr_i    = {5'd12, 5'd12, 5'd12};
    sb3.issue_i      = 1'b1;
    sb3.rd_en_i      = 3'b100;
    #1 chk("p2_stall", 64'(sb3.stall_o), 64'd1);
    sb3.rd_en_i      = 3'b000;
    #1 chk("p2_release", 64'(sb3.stall_o), 64'd0);
    sb3.rd_en_i      = 3'b001;
    #1 chk("p0_stall", 64'(sb3.stall_o), 64'd1);
    chk("p3_busy12", 64'(sb3.busy_o[12]), 64'd1);
    sb3.issue_i      = 1'b0;
    sb3.rd_en_i      = 3'b000;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
